efuse_multiword_ctrl: RTL and testbench

//  Parametrised successor to the single-word eFuse main FSM. Manages NUM_WORDS eFuse

---
 rtl/efuse_pkg.sv | 18 +
 rtl/efuse_shadow_regs.sv | 33 +++
 rtl/efuse_multiword_ctrl.sv | 156 +++++++++++++++
 tb/tb_efuse_multiword_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_pkg.sv
// rtl/efuse_pkg.sv - shared FSM encodings and error causes for the multiword eFuse controller
package efuse_pkg;

  localparam logic [1:0] ST_INIT_RD = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PGM     = 2'd2;
  localparam logic [1:0] ST_VERIFY  = 2'd3;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ADDR      = 2'd1;
  localparam logic [1:0] ERR_NOT_BLANK = 2'd2;
  localparam logic [1:0] ERR_BUSY      = 2'd3;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/efuse_shadow_regs.sv
// rtl/efuse_shadow_regs.sv - NUM_WORDS x DATA_W shadow bank with per-word write and bypass load
module efuse_shadow_regs #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bypass,
  input  logic [NUM_WORDS*DATA_W-1:0]   bypass_img,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [NUM_WORDS*DATA_W-1:0]   shadow
);

  logic [DATA_W-1:0] words [NUM_WORDS];

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    // bypass wins over a controller write landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        words[k] <= '0;
      end else if (bypass) begin
        words[k] <= bypass_img[k*DATA_W +: DATA_W];
      end else if (we && (waddr == ADDR_W'(k))) begin
        words[k] <= wdata;
      end
    end
    assign shadow[k*DATA_W +: DATA_W] = words[k];
  end

endmodule

// File: rtl/efuse_multiword_ctrl.sv
// rtl/efuse_multiword_ctrl.sv - eFuse main FSM: init sweep, blank-checked program with read-back verify
module efuse_multiword_ctrl
  import efuse_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = addr_width(NUM_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          efuse_bypass,
  input  logic [NUM_WORDS*DATA_W-1:0]   bypass_img,
  input  logic                          multi_en,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [NUM_WORDS*DATA_W-1:0]   shadow_out,
  output logic                          init_done,
  output logic                          busy,
  output logic                          ack,
  output logic                          wr_err,
  output logic                          vfy_err,
  output logic                          ctl_read,
  output logic                          ctl_write,
  output logic [ADDR_W-1:0]             ctl_addr,
  output logic [DATA_W-1:0]             ctl_wdata,
  input  logic                          rd_done,
  input  logic                          wr_done,
  input  logic [DATA_W-1:0]             rd_data
);

  localparam logic [ADDR_W:0]   WORDS_L  = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] job_addr;
  logic [DATA_W-1:0] job_mask;
  logic [DATA_W-1:0] job_old;
  logic              wr_req_q;
  logic              run;
  logic              wr_edge;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] mask_req;
  logic [1:0]        err_cause;
  logic              sh_we;
  logic [ADDR_W-1:0] sh_waddr;

  assign wr_edge  = wr_req && !wr_req_q;
  assign mask_req = wr_data & ~cur_word;

  // run keeps busy low while reset holds the FSM parked in INIT_RD
  assign busy      = run && (state != ST_IDLE);
  assign ctl_addr  = (state == ST_INIT_RD) ? idx : job_addr;
  assign ctl_wdata = job_mask;

  assign sh_we    = rd_done && ((state == ST_INIT_RD) || (state == ST_VERIFY));
  assign sh_waddr = (state == ST_INIT_RD) ? idx : job_addr;

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (wr_addr == ADDR_W'(k)) cur_word = shadow_out[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    err_cause = ERR_NONE;
    if (wr_edge) begin
      if (state != ST_IDLE)                    err_cause = ERR_BUSY;
      else if ({1'b0, wr_addr} >= WORDS_L)     err_cause = ERR_ADDR;
      else if (!multi_en && (cur_word != '0))  err_cause = ERR_NOT_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT_RD;
      idx       <= '0;
      job_addr  <= '0;
      job_mask  <= '0;
      job_old   <= '0;
      wr_req_q  <= 1'b0;
      run       <= 1'b0;
      init_done <= 1'b0;
      ack       <= 1'b0;
      wr_err    <= 1'b0;
      vfy_err   <= 1'b0;
      ctl_read  <= 1'b0;
      ctl_write <= 1'b0;
    end else begin
      run      <= 1'b1;
      wr_req_q <= wr_req;
      ack      <= 1'b0;
      vfy_err  <= 1'b0;
      wr_err   <= (err_cause != ERR_NONE);
      case (state)
        ST_INIT_RD: begin
          ctl_read <= !rd_done;
          if (rd_done) begin
            ack <= 1'b1;
            if (idx == LAST_IDX) begin
              idx       <= '0;
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (wr_edge && (err_cause == ERR_NONE)) begin
            // every requested bit already blown: acknowledge without touching the fuse
            if (mask_req == '0) begin
              ack <= 1'b1;
            end else begin
              job_addr <= wr_addr;
              job_mask <= mask_req;
              job_old  <= cur_word;
              state    <= ST_PGM;
            end
          end
        end
        ST_PGM: begin
          ctl_write <= !wr_done;
          if (wr_done) state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          ctl_read <= !rd_done;
          if (rd_done) begin
            ack     <= 1'b1;
            vfy_err <= (rd_data != (job_old | job_mask));
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  efuse_shadow_regs #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .bypass     (efuse_bypass),
    .bypass_img (bypass_img),
    .we         (sh_we),
    .waddr      (sh_waddr),
    .wdata      (rd_data),
    .shadow     (shadow_out)
  );

endmodule

// File: tb/tb_efuse_multiword_ctrl.sv
// tb/tb_efuse_multiword_ctrl.sv - self-checking bench: controller model, pulse scoreboard, write vector table
module tb_efuse_multiword_ctrl;

  localparam int DW  = 8;
  localparam int NW  = 5;
  localparam int AW  = 3;
  localparam int LAT = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               efuse_bypass = 1'b0;
  logic [NW*DW-1:0]   bypass_img = '0;
  logic               multi_en = 1'b0;
  logic               wr_req = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [DW-1:0]      wr_data = '0;
  logic [NW*DW-1:0]   shadow_out;
  logic               init_done, busy, ack, wr_err, vfy_err;
  logic               ctl_read, ctl_write;
  logic [AW-1:0]      ctl_addr;
  logic [DW-1:0]      ctl_wdata;
  logic               rd_done, wr_done;
  logic [DW-1:0]      rd_data;

  efuse_multiword_ctrl #(.DATA_W(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .efuse_bypass(efuse_bypass), .bypass_img(bypass_img),
    .multi_en(multi_en), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .shadow_out(shadow_out), .init_done(init_done), .busy(busy), .ack(ack),
    .wr_err(wr_err), .vfy_err(vfy_err), .ctl_read(ctl_read), .ctl_write(ctl_write),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .rd_done(rd_done), .wr_done(wr_done),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ack;
    logic wr_err;
    logic vfy_err;
  } pulse_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          multi;
    pulse_t        pulse;
    int            word_idx;
    logic [DW-1:0] exp_word;
    int            exp_writes;
    logic [DW-1:0] exp_blow;
  } vec_t;

  pulse_t        exp_q[$];
  pulse_t        mon_e;
  vec_t          vecs[7];
  int            total = 0;
  int            bad = 0;
  logic          overlap = 1'b0;

  // controller model state
  logic [DW-1:0] fuse [8];
  logic          force_zero = 1'b0;
  int            wr_cnt = 0;
  logic [DW-1:0] last_blow = '0;

  initial begin
    int rc, wc;
    fuse[0] = 8'h11; fuse[1] = 8'h22; fuse[2] = 8'h00; fuse[3] = 8'h44;
    fuse[4] = 8'h55; fuse[5] = 8'h00; fuse[6] = 8'h00; fuse[7] = 8'h00;
    rd_done = 1'b0; wr_done = 1'b0; rd_data = '0; rc = 0; wc = 0;
    forever begin
      @(negedge clk);
      rd_done = 1'b0;
      wr_done = 1'b0;
      if (ctl_read) rc++; else rc = 0;
      if (ctl_write) wc++; else wc = 0;
      if (rc == LAT) begin
        rd_done = 1'b1;
        rd_data = force_zero ? '0 : fuse[ctl_addr];
      end
      if (wc == LAT) begin
        wr_done = 1'b1;
        fuse[ctl_addr] = fuse[ctl_addr] | ctl_wdata;
        last_blow = ctl_wdata;
        wr_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [DW-1:0] word(input int k);
    return shadow_out[k*DW +: DW];
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || !init_done || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout(name);
  endtask

  task automatic wait_strobe(input string name, input bit wr);
    int n = 0;
    while (!(wr ? ctl_write : ctl_read) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout(name);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic m);
    wr_addr  = a;
    wr_data  = d;
    multi_en = m;
    @(negedge clk);
    wr_req = 1'b1;
    wait_idle("write_done");
    wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_acks(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
  endtask

  initial begin
    int wc0;
    vecs[0] = '{3'd2, 8'hA5, 1'b0, 3'b100, 2, 8'hA5, 1, 8'hA5};
    vecs[1] = '{3'd1, 8'hFF, 1'b0, 3'b010, 1, 8'h22, 0, 8'h00};
    vecs[2] = '{3'd1, 8'hFF, 1'b1, 3'b100, 1, 8'hFF, 1, 8'hDD};
    vecs[3] = '{3'd5, 8'h01, 1'b1, 3'b010, 0, 8'h11, 0, 8'h00};
    vecs[4] = '{3'd7, 8'h01, 1'b1, 3'b010, 0, 8'h11, 0, 8'h00};
    vecs[5] = '{3'd3, 8'h44, 1'b1, 3'b100, 3, 8'h44, 0, 8'h00};
    vecs[6] = '{3'd4, 8'h0F, 1'b1, 3'b100, 4, 8'h5F, 1, 8'h0A};

    fork
      forever begin
        @(negedge clk);
        if (ack || wr_err || vfy_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {ack, wr_err, vfy_err}, 3'b000);
          end else begin
            mon_e = exp_q.pop_front();
            check("pulse", {ack, wr_err, vfy_err}, mon_e);
          end
        end
        if (ctl_read && ctl_write) overlap = 1'b1;
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_shadow", shadow_out, 0);
    check("rst_strobes", {ctl_read, ctl_write, ack, wr_err, vfy_err}, 0);

    // init sweep
    push_acks(NW);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sweep_busy", busy, 1);
    check("sweep_read", ctl_read, 1);
    check("sweep_addr0", ctl_addr, 0);
    wait_idle("sweep");
    check("sweep_shadow", shadow_out, 40'h55_44_00_22_11);
    check("sweep_done", init_done, 1);

    // write request table
    for (int i = 0; i < 7; i++) begin
      wc0 = wr_cnt;
      exp_q.push_back(vecs[i].pulse);
      do_write(vecs[i].addr, vecs[i].data, vecs[i].multi);
      check($sformatf("vec%0d_word", i), word(vecs[i].word_idx), vecs[i].exp_word);
      check($sformatf("vec%0d_writes", i), wr_cnt - wc0, vecs[i].exp_writes);
      if (vecs[i].exp_writes != 0) check($sformatf("vec%0d_blow", i), last_blow, vecs[i].exp_blow);
    end

    // read-back mismatch, plus a request edge while programming
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b101);
    force_zero = 1'b1;
    wr_addr = 3'd0; wr_data = 8'hA5; multi_en = 1'b1;
    @(negedge clk);
    wr_req = 1'b1;
    wait_strobe("vfy_pgm", 1'b1);
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    wr_req = 1'b1;
    wait_idle("vfy_done");
    force_zero = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
    check("vfy_blow", last_blow, 8'hA4);
    check("vfy_shadow", word(0), 8'h00);

    // reset during PGM aborts the job and restarts the sweep at word 0
    wc0 = wr_cnt;
    exp_q.push_back(3'b100);
    wr_addr = 3'd3; wr_data = 8'h80; multi_en = 1'b1;
    @(negedge clk);
    wr_req = 1'b1;
    wait_strobe("abort_pgm", 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_ctl_write", ctl_write, 0);
    check("abort_busy", busy, 0);
    check("abort_shadow", shadow_out, 0);
    check("abort_init_done", init_done, 0);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    push_acks(NW);
    rst_n = 1'b1;
    wait_strobe("abort_sweep", 1'b0);
    check("abort_restart_addr", ctl_addr, 0);
    wait_idle("abort_sweep_done");
    check("abort_shadow_after", shadow_out, 40'h5F_44_A5_FF_B5);
    check("abort_no_write", wr_cnt - wc0, 0);

    // bypass asserted mid-sweep
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    push_acks(NW);
    rst_n = 1'b1;
    begin
      int n = 0;
      while (!(ctl_read && ctl_addr == 3'd2) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) timeout("byp_wait_word2");
    end
    bypass_img = 40'h5A_EF_BE_AD_DE;
    efuse_bypass = 1'b1;
    @(negedge clk);
    check("byp_track", shadow_out, 40'h5A_EF_BE_AD_DE);
    wait_idle("byp_sweep");
    check("byp_sweep_shadow", shadow_out, 40'h5A_EF_BE_AD_DE);
    check("byp_init_done", init_done, 1);
    exp_q.push_back(3'b010);
    do_write(3'd0, 8'h01, 1'b0);
    check("byp_blank_shadow", shadow_out, 40'h5A_EF_BE_AD_DE);
    efuse_bypass = 1'b0;
    repeat (2) @(negedge clk);
    check("byp_hold", shadow_out, 40'h5A_EF_BE_AD_DE);

    check("strobe_overlap", overlap, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
